// File: rtl/reg_scoreboard_if.sv
// Register-hazard bus between ID/WB (master) and the issue-side write scoreboard (slave).
// Carries the issue record, the WB retire record and the per-operand hazard query.
interface reg_scoreboard_if #(
  parameter int LAT_W = 2
);
  logic             issue_valid;
  logic             issue_wen;
  logic [4:0]       issue_dst;
  logic [LAT_W-1:0] issue_latency;
  logic             wb_valid;
  logic [4:0]       wb_dst;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             rs_used;
  logic             rt_used;
  logic             rs_pending;
  logic             rt_pending;
  logic             s_hazard_stall;

  modport master (
    output issue_valid, issue_wen, issue_dst, issue_latency,
    output wb_valid, wb_dst,
    output rs, rt, rs_used, rt_used,
    input  rs_pending, rt_pending, s_hazard_stall
  );

  modport slave (
    input  issue_valid, issue_wen, issue_dst, issue_latency,
    input  wb_valid, wb_dst,
    input  rs, rt, rs_used, rt_used,
    output rs_pending, rt_pending, s_hazard_stall
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Issue-side GPR write tracker: per-register outstanding-write count and forwardable countdown.
// Optional sticky overflow/underflow flag built only when SCOREBOARD_ERR_CHECK_EN is defined.
module reg_scoreboard #(
  parameter int CNT_W = 2,
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             PIPELINE_READY,
  input  logic             flush,
  reg_scoreboard_if.slave  sb,
  output logic             sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Bit r summarises register r; bit 0 is constant zero so $zero never reports a hazard.
  logic [31:0] pend_vec;
  logic [31:0] cd_nz_vec;
  logic        advance;
  logic        do_issue;
  logic        do_ret;

  assign pend_vec[0]  = 1'b0;
  assign cd_nz_vec[0] = 1'b0;

  assign sb.rs_pending     = pend_vec[sb.rs];
  assign sb.rt_pending     = pend_vec[sb.rt];
  assign sb.s_hazard_stall = (sb.rs_used & pend_vec[sb.rs] & cd_nz_vec[sb.rs]) |
                             (sb.rt_used & pend_vec[sb.rt] & cd_nz_vec[sb.rt]);

  assign advance  = PIPELINE_READY & ~flush;
  assign do_issue = advance & sb.issue_valid & sb.issue_wen & (sb.issue_dst != 5'd0) &
                    ~sb.s_hazard_stall;
  assign do_ret   = advance & sb.wb_valid & (sb.wb_dst != 5'd0);

`ifdef SCOREBOARD_ERR_CHECK_EN
  logic [31:0] err_vec;
  assign err_vec[0] = 1'b0;
`endif

  for (genvar r = 1; r < 32; r++) begin : g_reg
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] cd_q, cd_d;
    logic             issue_hit;
    logic             ret_hit;

    assign issue_hit = do_issue & (sb.issue_dst == 5'(r));
    assign ret_hit   = do_ret & (sb.wb_dst == 5'(r));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
      cnt_d = cnt_q;
      cd_d  = (cd_q != '0) ? cd_q - LAT_W'(1) : cd_q;
      if (issue_hit && !ret_hit) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else if (ret_hit && !issue_hit) begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      // Youngest writer's latency wins; the last retire leaves nothing to wait for.
      if (issue_hit)                 cd_d = sb.issue_latency;
      else if (ret_hit && cnt_d == '0) cd_d = '0;
    end

    // NOTE: state registers use non-blocking assignments so all 31 entries update off the same edge values.
    // NOTE: the per-register state is tiny flops, not RAM, so it is reset explicitly.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        cd_q  <= '0;
      end else if (flush) begin
        cnt_q <= '0;
        cd_q  <= '0;
      end else if (PIPELINE_READY) begin
        cnt_q <= cnt_d;
        cd_q  <= cd_d;
      end
    end

    assign pend_vec[r]  = |cnt_q;
    assign cd_nz_vec[r] = |cd_q;

`ifdef SCOREBOARD_ERR_CHECK_EN
    assign err_vec[r] = (issue_hit & ~ret_hit & (cnt_q == CNT_MAX)) |
                        (ret_hit & ~issue_hit & (cnt_q == '0));
`endif
  end

`ifdef SCOREBOARD_ERR_CHECK_EN
  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      sb_err <= 1'b0;
    else if (|err_vec) sb_err <= 1'b1;
  end
`else
  assign sb_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard: reset, load-use, ALU forwarding, freeze,
// $zero and same-cycle issue/retire, flush, saturation and underflow.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic PIPELINE_READY;
  logic flush;
  logic sb_err;
  int   checks = 0;
  int   errors = 0;

  reg_scoreboard_if #(.LAT_W(2)) sb_if ();

  reg_scoreboard #(.CNT_W(2), .LAT_W(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .PIPELINE_READY (PIPELINE_READY),
    .flush          (flush),
    .sb             (sb_if.slave),
    .sb_err         (sb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.issue_valid   = 1'b0;
    sb_if.issue_wen     = 1'b0;
    sb_if.issue_dst     = 5'd0;
    sb_if.issue_latency = 2'd0;
    sb_if.wb_valid      = 1'b0;
    sb_if.wb_dst        = 5'd0;
    sb_if.rs            = 5'd0;
    sb_if.rt            = 5'd0;
    sb_if.rs_used       = 1'b0;
    sb_if.rt_used       = 1'b0;
    flush               = 1'b0;
    PIPELINE_READY      = 1'b1;
  endtask

  task automatic set_issue(input logic [4:0] dst, input logic [1:0] lat);
    sb_if.issue_valid   = 1'b1;
    sb_if.issue_wen     = 1'b1;
    sb_if.issue_dst     = dst;
    sb_if.issue_latency = lat;
  endtask

  task automatic clr_issue();
    sb_if.issue_valid = 1'b0;
    sb_if.issue_wen   = 1'b0;
  endtask

  task automatic retire(input logic [4:0] dst);
    sb_if.wb_valid = 1'b1;
    sb_if.wb_dst   = dst;
    tick();
    sb_if.wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    sb_if.rs = 5'd5; sb_if.rs_used = 1'b1;
    #1;
    checks++; if (sb_if.rs_pending !== 1'b0) begin errors++; $display("FAIL reset_rs_pending: got %b want 0", sb_if.rs_pending); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err: got %b want 0", sb_err); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    set_issue(5'd5, 2'd0);
    tick(); tick();
    clr_issue();
    #1;
    checks++; if (sb_if.rs_pending !== 1'b1) begin errors++; $display("FAIL reset_pre_pending: got %b want 1", sb_if.rs_pending); end
    reset_n = 1'b0;
    #1;
    checks++; if (sb_if.rs_pending !== 1'b0) begin errors++; $display("FAIL reset_async_pending: got %b want 0", sb_if.rs_pending); end
    checks++; if (sb_if.s_hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_async_stall: got %b want 0", sb_if.s_hazard_stall); end
    #3 reset_n = 1'b1;
    tick();
    checks++; if (sb_if.rs_pending !== 1'b0) begin errors++; $display("FAIL reset_after_release: got %b want 0", sb_if.rs_pending); end
    idle();
  endtask

  task automatic test_load_use();
    idle();
    set_issue(5'd8, 2'd1);
    tick();
    clr_issue();
    sb_if.rs = 5'd8; sb_if.rs_used = 1'b1;
    #1;
    checks++; if (sb_if.s_hazard_stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b want 1", sb_if.s_hazard_stall); end
    checks++; if (sb_if.rs_pending !== 1'b1) begin errors++; $display("FAIL load_use_pending: got %b want 1", sb_if.rs_pending); end
    tick();
    checks++; if (sb_if.s_hazard_stall !== 1'b0) begin errors++; $display("FAIL load_use_stall_drop: got %b want 0", sb_if.s_hazard_stall); end
    checks++; if (sb_if.rs_pending !== 1'b1) begin errors++; $display("FAIL load_use_fwd_pending: got %b want 1", sb_if.rs_pending); end
    sb_if.wb_valid = 1'b1; sb_if.wb_dst = 5'd8;
    #1;
    checks++; if (sb_if.rs_pending !== 1'b1) begin errors++; $display("FAIL load_use_wb_same_cycle: got %b want 1", sb_if.rs_pending); end
    tick();
    sb_if.wb_valid = 1'b0;
    #1;
    checks++; if (sb_if.rs_pending !== 1'b0) begin errors++; $display("FAIL load_use_retired: got %b want 0", sb_if.rs_pending); end
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    set_issue(5'd9, 2'd0);
    tick();
    clr_issue();
    sb_if.rt = 5'd9; sb_if.rt_used = 1'b1;
    #1;
    checks++; if (sb_if.rt_pending !== 1'b1) begin errors++; $display("FAIL alu_rt_pending: got %b want 1", sb_if.rt_pending); end
    checks++; if (sb_if.s_hazard_stall !== 1'b0) begin errors++; $display("FAIL alu_no_stall: got %b want 0", sb_if.s_hazard_stall); end
    set_issue(5'd9, 2'd0);
    tick();
    clr_issue();
    retire(5'd9);
    #1;
    checks++; if (sb_if.rt_pending !== 1'b1) begin errors++; $display("FAIL alu_one_left: got %b want 1", sb_if.rt_pending); end
    retire(5'd9);
    #1;
    checks++; if (sb_if.rt_pending !== 1'b0) begin errors++; $display("FAIL alu_all_retired: got %b want 0", sb_if.rt_pending); end
    idle();
  endtask

  task automatic test_freeze();
    idle();
    set_issue(5'd10, 2'd1);
    tick();
    clr_issue();
    sb_if.rs = 5'd10; sb_if.rs_used = 1'b1;
    PIPELINE_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (sb_if.s_hazard_stall !== 1'b1) begin errors++; $display("FAIL freeze_stall_%0d: got %b want 1", i, sb_if.s_hazard_stall); end
      tick();
    end
    PIPELINE_READY = 1'b1;
    #1;
    checks++; if (sb_if.s_hazard_stall !== 1'b1) begin errors++; $display("FAIL freeze_resume_stall: got %b want 1", sb_if.s_hazard_stall); end
    tick();
    checks++; if (sb_if.s_hazard_stall !== 1'b0) begin errors++; $display("FAIL freeze_stall_drop: got %b want 0", sb_if.s_hazard_stall); end
    checks++; if (sb_if.rs_pending !== 1'b1) begin errors++; $display("FAIL freeze_pending: got %b want 1", sb_if.rs_pending); end
    retire(5'd10);
    idle();
  endtask

  task automatic test_simul_zero();
    idle();
    set_issue(5'd0, 2'd1);
    tick();
    clr_issue();
    sb_if.rs = 5'd0; sb_if.rs_used = 1'b1; sb_if.rt = 5'd0; sb_if.rt_used = 1'b1;
    #1;
    checks++; if (sb_if.rs_pending !== 1'b0) begin errors++; $display("FAIL zero_pending: got %b want 0", sb_if.rs_pending); end
    checks++; if (sb_if.s_hazard_stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b want 0", sb_if.s_hazard_stall); end
    idle();
    set_issue(5'd12, 2'd0);
    tick();
    set_issue(5'd12, 2'd1);
    sb_if.wb_valid = 1'b1; sb_if.wb_dst = 5'd12;
    tick();
    clr_issue();
    sb_if.wb_valid = 1'b0;
    sb_if.rs = 5'd12; sb_if.rs_used = 1'b1;
    #1;
    checks++; if (sb_if.rs_pending !== 1'b1) begin errors++; $display("FAIL simul_pending: got %b want 1", sb_if.rs_pending); end
    checks++; if (sb_if.s_hazard_stall !== 1'b1) begin errors++; $display("FAIL simul_cd_loaded: got %b want 1", sb_if.s_hazard_stall); end
    tick();
    checks++; if (sb_if.s_hazard_stall !== 1'b0) begin errors++; $display("FAIL simul_cd_expired: got %b want 0", sb_if.s_hazard_stall); end
    retire(5'd12);
    #1;
    checks++; if (sb_if.rs_pending !== 1'b0) begin errors++; $display("FAIL simul_cnt_was_one: got %b want 0", sb_if.rs_pending); end
    idle();
  endtask

  task automatic test_flush();
    idle();
    set_issue(5'd3, 2'd0);
    tick();
    set_issue(5'd4, 2'd0);
    tick(); tick(); tick();
    clr_issue();
    sb_if.rs = 5'd3; sb_if.rt = 5'd4;
    #1;
    checks++; if (sb_if.rs_pending !== 1'b1) begin errors++; $display("FAIL flush_pre_rs: got %b want 1", sb_if.rs_pending); end
    checks++; if (sb_if.rt_pending !== 1'b1) begin errors++; $display("FAIL flush_pre_rt: got %b want 1", sb_if.rt_pending); end
    flush = 1'b1;
    set_issue(5'd3, 2'd0);
    tick();
    flush = 1'b0;
    clr_issue();
    #1;
    checks++; if (sb_if.rs_pending !== 1'b0) begin errors++; $display("FAIL flush_rs_cleared: got %b want 0", sb_if.rs_pending); end
    checks++; if (sb_if.rt_pending !== 1'b0) begin errors++; $display("FAIL flush_rt_cleared: got %b want 0", sb_if.rt_pending); end
    set_issue(5'd5, 2'd0);
    tick();
    clr_issue();
    PIPELINE_READY = 1'b0;
    flush = 1'b1;
    tick();
    idle();
    sb_if.rs = 5'd5;
    #1;
    checks++; if (sb_if.rs_pending !== 1'b0) begin errors++; $display("FAIL flush_while_frozen: got %b want 0", sb_if.rs_pending); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL flush_no_err_yet: got %b want 0", sb_err); end
    idle();
  endtask

  task automatic test_saturate();
    idle();
    set_issue(5'd4, 2'd0);
    tick(); tick(); tick();
    #1;
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sat_no_err_at_max: got %b want 0", sb_err); end
    tick();
    clr_issue();
    #1;
    checks++; if (sb_err !== ERR_EN) begin errors++; $display("FAIL sat_sb_err: got %b want %b", sb_err, ERR_EN); end
    sb_if.rs = 5'd4;
    retire(5'd4);
    retire(5'd4);
    #1;
    checks++; if (sb_if.rs_pending !== 1'b1) begin errors++; $display("FAIL sat_held_at_three: got %b want 1", sb_if.rs_pending); end
    retire(5'd4);
    #1;
    checks++; if (sb_if.rs_pending !== 1'b0) begin errors++; $display("FAIL sat_drained: got %b want 0", sb_if.rs_pending); end
    idle();
  endtask

  task automatic test_underflow();
    idle();
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL under_err_reset: got %b want 0", sb_err); end
    retire(5'd7);
    sb_if.rs = 5'd7;
    #1;
    checks++; if (sb_err !== ERR_EN) begin errors++; $display("FAIL under_sb_err: got %b want %b", sb_err, ERR_EN); end
    checks++; if (sb_if.rs_pending !== 1'b0) begin errors++; $display("FAIL under_pending: got %b want 0", sb_if.rs_pending); end
    set_issue(5'd7, 2'd0);
    tick();
    clr_issue();
    #1;
    checks++; if (sb_if.rs_pending !== 1'b1) begin errors++; $display("FAIL under_held_zero: got %b want 1", sb_if.rs_pending); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++; if (sb_err !== ERR_EN) begin errors++; $display("FAIL under_err_sticky: got %b want %b", sb_err, ERR_EN); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_back_to_back();
    test_freeze();
    test_simul_zero();
    test_flush();
    test_saturate();
    test_underflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
